// File: rtl/tnn_popcount_pkg.sv
// Shared definitions for the ternary-neuron popcount accumulator:
// activation encodings, controller states and width helpers.
package tnn_popcount_pkg;

  localparam logic [1:0] ACT_POS  = 2'b01;
  localparam logic [1:0] ACT_ZERO = 2'b00;
  localparam logic [1:0] ACT_NEG  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // Bits needed to hold a popcount of in_w inputs (0..in_w).
  function automatic int pc_width(input int in_w);
    return $clog2(in_w + 1);
  endfunction

  // Signed width covering +/- in_w*max_beats.
  function automatic int sum_width(input int in_w, input int max_beats);
    return $clog2(in_w * max_beats + 1) + 1;
  endfunction

endpackage

// File: rtl/popcount_tree.sv
// Exact combinational popcount. The port list is kept minimal so an
// approximate tree can replace it later without touching the parent.
module popcount_tree
  import tnn_popcount_pkg::*;
#(
  parameter int IN_W = 25
) (
  input  logic [IN_W-1:0]           bits,
  output logic [pc_width(IN_W)-1:0] count
);

  localparam int PC_W = pc_width(IN_W);

  always_comb begin
    // NOTE: blocking '=' is correct here; count is a running combinational
    // temporary rebuilt every evaluation, not stored state.
    count = '0;
    for (int i = 0; i < IN_W; i++) begin
      count = count + PC_W'(bits[i]);
    end
  end

endmodule

// File: rtl/ternary_popcount_accum.sv
// Streaming ternary neuron: accumulates popcount(pos) - popcount(neg) over
// up to MAX_BEATS beats and classifies the sum against two thresholds.
module ternary_popcount_accum
  import tnn_popcount_pkg::*;
#(
  parameter int IN_W      = 25,
  parameter int MAX_BEATS = 8,
  parameter int PC_W      = pc_width(IN_W),
  parameter int SUM_W     = sum_width(IN_W, MAX_BEATS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [IN_W-1:0]  s_pos,
  input  logic [IN_W-1:0]  s_neg,
  input  logic             s_last,
  input  logic [SUM_W-1:0] th_hi,
  input  logic [SUM_W-1:0] th_lo,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [1:0]       m_act,
  output logic [SUM_W-1:0] m_sum,
  output logic             m_trunc
);

  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  state_t state_q, state_d;

  logic signed [SUM_W-1:0] sum_q;
  logic        [CNT_W-1:0] cnt_q;
  logic signed [SUM_W-1:0] th_hi_q, th_lo_q;
  logic        [1:0]       act_q;
  logic signed [SUM_W-1:0] res_sum_q;
  logic                    trunc_q;

  logic [PC_W-1:0] pc_pos, pc_neg;

  popcount_tree #(.IN_W(IN_W)) u_pc_pos (.bits(s_pos), .count(pc_pos));
  popcount_tree #(.IN_W(IN_W)) u_pc_neg (.bits(s_neg), .count(pc_neg));

  logic                    accept;
  logic                    first;
  logic                    done;
  logic signed [SUM_W-1:0] delta;
  logic signed [SUM_W-1:0] new_sum;
  logic        [CNT_W-1:0] new_cnt;
  logic signed [SUM_W-1:0] th_hi_eff, th_lo_eff;
  logic        [1:0]       act_d;

  assign s_ready = (state_q != ST_HOLD) || m_ready;
  assign accept  = s_valid && s_ready;
  // A beat taken while a result is being consumed opens a new evaluation.
  assign first   = (state_q != ST_ACC);

  assign delta = $signed({{(SUM_W-PC_W){1'b0}}, pc_pos})
               - $signed({{(SUM_W-PC_W){1'b0}}, pc_neg});

  assign new_sum   = first ? delta : (sum_q + delta);
  assign new_cnt   = first ? CNT_W'(1) : (cnt_q + CNT_W'(1));
  assign done      = s_last || (new_cnt == CNT_W'(MAX_BEATS));
  assign th_hi_eff = first ? $signed(th_hi) : th_hi_q;
  assign th_lo_eff = first ? $signed(th_lo) : th_lo_q;

  // Upper test first so it wins when the thresholds overlap.
  assign act_d = (new_sum >= th_hi_eff) ? ACT_POS :
                 (new_sum <= th_lo_eff) ? ACT_NEG : ACT_ZERO;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    // NOTE: state_d gets a default before the case so every path assigns
    // it; otherwise synthesis would infer a latch.
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_ACC: begin
        if (accept) state_d = done ? ST_HOLD : ST_ACC;
      end
      ST_HOLD: begin
        if (m_ready) begin
          if (accept) state_d = done ? ST_HOLD : ST_ACC;
          else        state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every register is a plain flop, so all of them are reset;
    // there is no memory array that would be left unreset.
    if (!rst_n) begin
      sum_q     <= '0;
      cnt_q     <= '0;
      th_hi_q   <= '0;
      th_lo_q   <= '0;
      act_q     <= ACT_ZERO;
      res_sum_q <= '0;
      trunc_q   <= 1'b0;
    end else if (accept) begin
      if (first) begin
        th_hi_q <= th_hi;
        th_lo_q <= th_lo;
      end
      if (done) begin
        sum_q     <= '0;
        cnt_q     <= '0;
        act_q     <= act_d;
        res_sum_q <= new_sum;
        trunc_q   <= !s_last;
      end else begin
        sum_q <= new_sum;
        cnt_q <= new_cnt;
      end
    end
  end

  // Result registers only load on an accepted beat, which in HOLD requires
  // m_ready, so they stay stable while a result is back-pressured.
  assign m_valid = (state_q == ST_HOLD);
  assign m_act   = act_q;
  assign m_sum   = res_sum_q;
  assign m_trunc = trunc_q;

endmodule

// File: tb/tb_ternary_popcount_accum.sv
// Directed bench for ternary_popcount_accum (IN_W=25, MAX_BEATS=8) with a
// short randomised run checked against an independent reference sum.
module tb_ternary_popcount_accum;

  localparam int IN_W      = 25;
  localparam int MAX_BEATS = 8;
  localparam int SUM_W     = $clog2(IN_W * MAX_BEATS + 1) + 1;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    s_valid;
  logic                    s_ready;
  logic [IN_W-1:0]         s_pos;
  logic [IN_W-1:0]         s_neg;
  logic                    s_last;
  logic signed [SUM_W-1:0] th_hi;
  logic signed [SUM_W-1:0] th_lo;
  logic                    m_valid;
  logic                    m_ready;
  logic [1:0]              m_act;
  logic signed [SUM_W-1:0] m_sum;
  logic                    m_trunc;

  int checks = 0;
  int errors = 0;

  ternary_popcount_accum #(.IN_W(IN_W), .MAX_BEATS(MAX_BEATS)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_pos(s_pos), .s_neg(s_neg),
    .s_last(s_last), .th_hi(th_hi), .th_lo(th_lo),
    .m_valid(m_valid), .m_ready(m_ready), .m_act(m_act), .m_sum(m_sum),
    .m_trunc(m_trunc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [IN_W-1:0] ones(input int n);
    logic [IN_W-1:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[i] = 1'b1;
    return r;
  endfunction

  // Drive one beat (inputs stay asserted afterwards) and step past the edge.
  task automatic beat(input logic [IN_W-1:0] p, input logic [IN_W-1:0] n,
                      input logic last);
    s_valid = 1'b1;
    s_pos   = p;
    s_neg   = n;
    s_last  = last;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    s_valid = 1'b0;
    s_last  = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic set_th(input int hi, input int lo);
    th_hi = SUM_W'(hi);
    th_lo = SUM_W'(lo);
  endtask

  task automatic three_beats(input int lo, input int exp_act, input string tag);
    set_th(5, lo);
    beat(ones(3), '0, 1'b0);
    set_th(-100, -100);               // later beats must not re-sample thresholds
    beat('0, ones(7), 1'b0);
    beat(ones(1), ones(3), 1'b1);
    check({tag, "_valid"}, m_valid, 1);
    check({tag, "_sum"}, m_sum, -6);
    check({tag, "_act"}, m_act, exp_act);
    idle();
  endtask

  initial begin
    int n_beats, ref_sum, hi, lo, exp_act;
    logic last;
    logic [IN_W-1:0] p, n;

    rst_n = 1'b0; s_valid = 1'b0; s_pos = '0; s_neg = '0; s_last = 1'b0;
    m_ready = 1'b1; set_th(0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", m_valid, 0);
    check("rst_act", m_act, 0);
    check("rst_sum", m_sum, 0);
    check("rst_trunc", m_trunc, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_ready", s_ready, 1);

    // Single full-positive beat.
    set_th(10, -10);
    beat(ones(25), '0, 1'b1);
    check("single_valid", m_valid, 1);
    check("single_sum", m_sum, 25);
    check("single_act", m_act, 1);
    check("single_trunc", m_trunc, 0);
    idle();
    check("single_consumed", m_valid, 0);

    // Three beats summing to -6 with varying lower threshold.
    three_beats(-5, 3, "tri_lo5");
    three_beats(-6, 3, "tri_lo6");
    three_beats(-7, 0, "tri_lo7");

    // Overlapping thresholds: +1 wins.
    set_th(-6, 0);
    beat(ones(2), ones(8), 1'b1);
    check("overlap_sum", m_sum, -6);
    check("overlap_act", m_act, 1);
    idle();

    // Force-close at MAX_BEATS, then an immediate fresh evaluation.
    set_th(100, -100);
    for (int i = 0; i < MAX_BEATS; i++) begin
      if (i == MAX_BEATS - 1) check("trunc_not_early", m_valid, 0);
      beat(ones(1), '0, 1'b0);
    end
    check("trunc_valid", m_valid, 1);
    check("trunc_sum", m_sum, 8);
    check("trunc_flag", m_trunc, 1);
    check("trunc_act", m_act, 0);
    beat(ones(2), '0, 1'b1);
    check("fresh_valid", m_valid, 1);
    check("fresh_sum", m_sum, 2);
    check("fresh_trunc", m_trunc, 0);
    idle();

    // Backpressure: result held, next beat waits, both move together.
    m_ready = 1'b0;
    set_th(2, -2);
    beat(ones(4), ones(1), 1'b1);
    check("bp_valid", m_valid, 1);
    set_th(10, 4);
    s_pos = ones(5);
    s_neg = '0;
    for (int i = 0; i < 5; i++) begin
      check("bp_ready_low", s_ready, 0);
      check("bp_hold_sum", m_sum, 3);
      check("bp_hold_act", m_act, 1);
      @(posedge clk); #1;
    end
    check("bp_still_valid", m_valid, 1);
    m_ready = 1'b1;
    #1;
    check("bp_ready_high", s_ready, 1);
    @(posedge clk); #1;
    check("bp_next_valid", m_valid, 1);
    check("bp_next_sum", m_sum, 5);
    check("bp_next_act", m_act, 0);
    idle();
    check("bp_drained", m_valid, 0);

    // Reset in the middle of an evaluation.
    set_th(50, -50);
    beat(ones(5), '0, 1'b0);
    beat(ones(5), '0, 1'b0);
    s_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("abort_valid", m_valid, 0);
    check("abort_sum", m_sum, 0);
    check("abort_act", m_act, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("abort_no_pulse", m_valid, 0);
    set_th(2, -2);
    beat(ones(3), '0, 1'b1);
    check("after_abort_sum", m_sum, 3);
    check("after_abort_act", m_act, 1);
    idle();

    // Randomised back-to-back evaluations against a reference sum.
    for (int e = 0; e < 300; e++) begin
      n_beats = $urandom_range(1, MAX_BEATS);
      hi = $urandom_range(0, 120) - 60;
      lo = $urandom_range(0, 120) - 60;
      set_th(hi, lo);
      ref_sum = 0;
      last = 1'b0;
      for (int b = 0; b < n_beats; b++) begin
        p = IN_W'($urandom());
        n = IN_W'($urandom());
        last = (b == n_beats - 1) && ((n_beats < MAX_BEATS) || ($urandom_range(0, 1) == 1));
        ref_sum += $countones(p) - $countones(n);
        beat(p, n, last);
        if (b == 0) set_th($urandom_range(0, 120) - 60, $urandom_range(0, 120) - 60);
        if (b < n_beats - 1) check("rnd_mid_valid", m_valid, 0);
      end
      exp_act = (ref_sum >= hi) ? 1 : (ref_sum <= lo) ? 3 : 0;
      check("rnd_valid", m_valid, 1);
      check("rnd_sum", m_sum, ref_sum);
      check("rnd_act", m_act, exp_act);
      check("rnd_trunc", m_trunc, !last);
    end
    idle();
    check("rnd_drained", m_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
